// File: rtl/mux4_arb_pkg.sv
// Shared types, source indices and round-robin helper for the mux4 arbiter.
package mux4_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  // First requesting index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); returns ptr if none request.
  function automatic logic [1:0] rr_next_idx(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] result;
    logic [1:0] idx;
    result = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (req[idx]) result = idx;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux4_w.sv
// Parameterized W-bit 4:1 multiplexer selected by {s1,s0}.
module mux4_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         s1,
  input  logic         s0,
  output logic [W-1:0] y
);

  always_comb begin
    case ({s1, s0})
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 mux.
// Optional forced rotation after MAX_HOLD granted cycles: define MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s0,
  output logic         valid,
  output logic [W-1:0] y
);

  arb_state_e state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       grant_new;
  logic [3:0] pick_req;
  logic [1:0] idx;
  logic [W-1:0] mux_y;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  logic [CW-1:0] hold_q, hold_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  // Since ptr sits just past the owner, scanning from ptr visits the owner last.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    grant_new = 1'b0;
    pick_req  = req;
`ifdef MUX4_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) grant_new = 1'b1;
      end
      default: begin
        if (req[sel_q]) begin
`ifdef MUX4_ARB_TIMEOUT_EN
          if ((hold_q == HOLD_MAX) && (|(req & ~gnt_q))) begin
            grant_new = 1'b1;
            pick_req  = req & ~gnt_q;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end else if (|req) begin
          grant_new = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
    endcase
    idx = rr_next_idx(pick_req, ptr_q);
    if (grant_new) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << idx;
      sel_d   = idx;
      ptr_d   = idx + 2'd1;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_d  = {{(CW-1){1'b0}}, 1'b1};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= SRC_A;
      ptr_q   <= SRC_A;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  mux4_w #(.W(W)) u_mux (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .s1 (sel_q[1]),
    .s0 (sel_q[0]),
    .y  (mux_y)
  );

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = |gnt_q;
  assign y     = valid ? mux_y : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed steps plus randomized traffic vs a reference model.
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b1111;
   logic [7:0] a = 8'h11, b = 8'h22, c = 8'h33, d = 8'h44;
   logic [3:0] gnt;
   logic       s1, s0, valid;
   logic [7:0] y;

   int passCount = 0;
   int checkCount = 0;
   int failCount = 0;

   int owner = -1;
   int ptr = 0;
   int hold = 0;
   int lastSel = 0;

   mux4_rr_arbiter #(.W(8), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req),
      .a(a), .b(b), .c(c), .d(d),
      .gnt(gnt), .s1(s1), .s0(s0), .valid(valid), .y(y)
   );

   always #5 clk = ~clk;

   // Reference model: integer owner/pointer, first requester found by modular scan.
   function automatic int pickIdx(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [7:0] dataOf(input int i);
      case (i)
         0: return a;
         1: return b;
         2: return c;
         default: return d;
      endcase
   endfunction

   task automatic grantTo(input int i);
      owner = i;
      ptr = (i + 1) % 4;
      hold = 1;
      lastSel = i;
   endtask

   task automatic modelReset();
      owner = -1;
      ptr = 0;
      hold = 0;
      lastSel = 0;
   endtask

   // Advance the model by one clock edge using the request vector sampled there.
   task automatic modelEdge(input logic [3:0] r);
      logic [3:0] others;
      if (owner < 0) begin
         if (r != 4'b0000) grantTo(pickIdx(r, ptr));
      end else if (r[owner]) begin
`ifdef MUX4_ARB_TIMEOUT_EN
         others = r & ~(4'b0001 << owner);
         if (hold == MAX_HOLD && others != 4'b0000) grantTo(pickIdx(others, ptr));
         else if (hold < MAX_HOLD) hold++;
`else
         others = 4'b0000;
`endif
      end else if (r != 4'b0000) begin
         grantTo(pickIdx(r, ptr));
      end else begin
         owner = -1;
      end
   endtask

   task automatic checkValue(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checkCount++;
      assert (got === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare every output against the model's view of the current grant.
   task automatic checkOutput(input string tag);
      logic [3:0] expGnt;
      logic [1:0] expSel;
      expGnt = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
      expSel = 2'(lastSel);
      checkValue({tag, ".gnt"}, {4'b0, gnt}, {4'b0, expGnt});
      checkValue({tag, ".sel"}, {6'b0, s1, s0}, {6'b0, expSel});
      checkValue({tag, ".valid"}, {7'b0, valid}, {7'b0, owner >= 0});
      checkValue({tag, ".y"}, y, (owner < 0) ? 8'h00 : dataOf(owner));
   endtask

   task automatic applyStimulus(input logic [3:0] r, input int cycles, input string tag);
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         req = r;
         @(posedge clk);
         modelEdge(r);
         #1;
         checkOutput(tag);
      end
   endtask

   initial begin
      $display("[TB] start");
      modelReset();

      // Reset held with all sources requesting: outputs stay cleared.
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         checkOutput("reset");
      end
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b1111, 1, "firstGrant");
      checkValue("firstGrantA", {4'b0, gnt}, 8'h01);
      checkValue("firstGrantY", y, 8'h11);

      // Single requester c.
      applyStimulus(4'b0000, 1, "idle");
      c = 8'hA5;
      applyStimulus(4'b0100, 1, "singleC");
      checkValue("singleCsel", {6'b0, s1, s0}, 8'h02);
      checkValue("singleCy", y, 8'hA5);
      applyStimulus(4'b0100, 5, "holdC");
      applyStimulus(4'b0000, 1, "dropC");
      checkValue("dropCvalid", {7'b0, valid}, 8'h00);

      // Fair rotation: each owner drops its request for one cycle.
      applyStimulus(4'b1111, 1, "rotStart");
      for (int n = 0; n < 8; n++) begin
         applyStimulus(4'b1111 & ~(4'b0001 << owner), 1, "rotate");
      end

      // Pointer wrap: after d, a outranks b.
      applyStimulus(4'b0000, 1, "idle2");
      applyStimulus(4'b1000, 1, "grantD");
      applyStimulus(4'b0011, 1, "wrap");
      checkValue("wrapToA", {4'b0, gnt}, 8'h01);

      // Long hold by a while b waits.
      applyStimulus(4'b0000, 1, "idle3");
      applyStimulus(4'b0001, 1, "holdA");
`ifdef MUX4_ARB_TIMEOUT_EN
      applyStimulus(4'b0011, 7, "timeoutWait");
      checkValue("timeoutStillA", {4'b0, gnt}, 8'h01);
      applyStimulus(4'b0011, 1, "timeoutFire");
      checkValue("timeoutToB", {4'b0, gnt}, 8'h02);
`else
      applyStimulus(4'b0011, 22, "noTimeout");
      checkValue("noTimeoutA", {4'b0, gnt}, 8'h01);
`endif

      // Async reset mid-grant, then restart from ptr 0.
      applyStimulus(4'b0000, 1, "idle4");
      applyStimulus(4'b0100, 2, "preReset");
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkValue("asyncGnt", {4'b0, gnt}, 8'h00);
      checkOutput("asyncReset");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b1100, 1, "ptrRestart");
      checkValue("ptrRestartC", {4'b0, gnt}, 8'h04);

      // Randomized traffic with sticky requests and changing data.
      for (int n = 0; n < 400; n++) begin
         logic [3:0] r;
         r = ($urandom_range(0, 3) != 0) ? req : 4'($urandom_range(0, 15));
         @(negedge clk);
         a = 8'($urandom);
         b = 8'($urandom);
         c = 8'($urandom);
         d = 8'($urandom);
         req = r;
         @(posedge clk);
         modelEdge(r);
         #1;
         checkOutput("random");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
